// File: rtl/aes_block_sequencer_if.sv
// aes_block_sequencer_if: groups the byte-stream transport, key loading,
// encryptor-side and status signals of aes_block_sequencer into one bundle.
// slave  = the sequencer's view; master = the surrounding system's view.
interface aes_block_sequencer_if;
  // key loading
  logic [127:0] key_in;
  logic         key_load;
  // byte input stream
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  // byte output stream
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  // encryptor core side
  logic [127:0] aes_key;
  logic [127:0] aes_plaintext;
  logic         aes_start;
  logic [127:0] aes_ciphertext;
  logic         aes_valid;
  // status
  logic         busy;
  logic         blk_done;
  logic         aes_err;

  modport slave (
    input  key_in, key_load,
    input  in_data, in_valid,
    output in_ready,
    output out_data, out_valid,
    input  out_ready,
    output aes_key, aes_plaintext, aes_start,
    input  aes_ciphertext, aes_valid,
    output busy, blk_done, aes_err
  );

  modport master (
    output key_in, key_load,
    output in_data, in_valid,
    input  in_ready,
    input  out_data, out_valid,
    output out_ready,
    input  aes_key, aes_plaintext, aes_start,
    output aes_ciphertext, aes_valid,
    input  busy, blk_done, aes_err
  );
endinterface

// File: rtl/aes_block_sequencer.sv
// aes_block_sequencer: byte-stream front/back end for aes_encryptor_top.
// Collects 16 plaintext bytes (byte 0 -> bits [127:120]), pulses aes_start,
// holds key/plaintext until the core's valid pulse, captures the ciphertext
// and streams it out as 16 bytes in the same order.
// Optional feature: define AES_SEQ_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles without aes_valid (sets sticky aes_err).
module aes_block_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  aes_block_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_SEND
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   byte_cnt_q, byte_cnt_d;
  logic [127:0] key_q, key_d;
  logic [127:0] pt_q, pt_d;
  logic [127:0] ct_q, ct_d;
  logic         blk_done_q, blk_done_d;
  logic         rdy_en_q;

  logic [6:0]   byte_pos;
  logic         last_byte;
  logic         in_ready_w;
  logic         in_hs;

  // Bit offset of the current byte: 8*(15-byte_cnt), byte 0 at the MSB end.
  assign byte_pos   = {~byte_cnt_q, 3'b000};
  assign last_byte  = (byte_cnt_q == 4'd15);
  // rdy_en_q keeps in_ready low while reset is asserted even though LOAD is
  // the reset state.
  assign in_ready_w = (state_q == ST_LOAD) && rdy_en_q;
  assign in_hs      = bus.in_valid && in_ready_w;

`ifdef AES_SEQ_TIMEOUT_EN
  localparam int unsigned        WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic              wait_expired;

  assign wait_expired = (wait_cnt_q == WAIT_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  // Next-state, byte counter and datapath register updates.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    key_d      = key_q;
    pt_d       = pt_q;
    ct_d       = ct_q;
    blk_done_d = 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
    err_d      = err_q;
    wait_cnt_d = '0;
`endif

    unique case (state_q)
      ST_LOAD: begin
        // key_load is only honoured between blocks; it may coincide with byte 0.
        if (bus.key_load && (byte_cnt_q == 4'd0)) begin
          key_d = bus.key_in;
        end
        if (in_hs) begin
          pt_d[byte_pos +: 8] = bus.in_data;
          byte_cnt_d          = byte_cnt_q + 4'd1;
`ifdef AES_SEQ_TIMEOUT_EN
          err_d               = 1'b0;
`endif
          if (last_byte) begin
            state_d = ST_START;
          end
        end
      end

      ST_START: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (bus.aes_valid) begin
          ct_d    = bus.aes_ciphertext;
          state_d = ST_SEND;
        end
`ifdef AES_SEQ_TIMEOUT_EN
        else if (wait_expired) begin
          err_d   = 1'b1;
          state_d = ST_LOAD;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
`endif
      end

      ST_SEND: begin
        if (bus.out_ready) begin
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (last_byte) begin
            blk_done_d = 1'b1;
            state_d    = ST_LOAD;
          end
        end
      end

      default: begin
        state_d    = ST_LOAD;
        byte_cnt_d = '0;
      end
    endcase
  end

  // State, counter and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_LOAD;
      byte_cnt_q <= '0;
      key_q      <= '0;
      pt_q       <= '0;
      ct_q       <= '0;
      blk_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      key_q      <= key_d;
      pt_q       <= pt_d;
      ct_q       <= ct_d;
      blk_done_q <= blk_done_d;
    end
  end

  // Input-ready enable: rises on the first clock after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

`ifdef AES_SEQ_TIMEOUT_EN
  // WAIT cycle counter and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus.aes_err = err_q;
`else
  assign bus.aes_err = 1'b0;
`endif

  assign bus.in_ready      = in_ready_w;
  assign bus.out_valid     = (state_q == ST_SEND);
  assign bus.out_data      = (state_q == ST_SEND) ? ct_q[byte_pos +: 8] : '0;
  assign bus.aes_start     = (state_q == ST_START);
  assign bus.aes_key       = key_q;
  assign bus.aes_plaintext = pt_q;
  assign bus.busy          = (state_q != ST_LOAD);
  assign bus.blk_done      = blk_done_q;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// tb_aes_block_sequencer: directed bench for aes_block_sequencer. The bench
// plays the byte source, the byte sink and the encryptor core; expected
// output bytes are queued when a block is sent and popped on each handshake.
module tb_aes_block_sequencer;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ALT_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ALT_PT   = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  aes_block_sequencer_if bus ();

  aes_block_sequencer #(.TIMEOUT_CYCLES(64)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int           n_cmp = 0;
  int           n_err = 0;
  logic [7:0]   exp_q[$];
  logic [127:0] exp_key;

  // Stand-in encryption: the real FIPS-197 vector, anything else a keyed mix.
  function automatic logic [127:0] model_ct(input logic [127:0] pt, input logic [127:0] key);
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    return pt ^ {key[63:0], key[127:64]} ^ 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: observed no response expected handshake within budget", tag);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready"},  bus.in_ready, 1'b0);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_out_data"},  bus.out_data, 8'h00);
    chk({tag, "_aes_start"}, bus.aes_start, 1'b0);
    chk({tag, "_busy"},      bus.busy, 1'b0);
    chk({tag, "_blk_done"},  bus.blk_done, 1'b0);
    chk({tag, "_aes_err"},   bus.aes_err, 1'b0);
    chk({tag, "_aes_key"},   bus.aes_key, 128'h0);
    chk({tag, "_aes_pt"},    bus.aes_plaintext, 128'h0);
  endtask

  // Streams 16 bytes; optional key_load alongside byte kl_at. Returns at the
  // negedge of the first WAIT cycle. keep_valid leaves junk bytes offered.
  task automatic send_block(input logic [127:0] pt, input int kl_at,
                            input logic [127:0] kl_key, input bit keep_valid);
    logic [127:0] ct;
    for (int i = 0; i < 16; i++) begin
      int g;
      g = 0;
      while (bus.in_ready !== 1'b1 && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (g >= 50) begin
        timeout_fail("in_ready_wait");
        break;
      end
      bus.in_data  = pt[127-8*i -: 8];
      bus.in_valid = 1'b1;
      if (i == kl_at) begin
        bus.key_load = 1'b1;
        bus.key_in   = kl_key;
        if (i == 0) exp_key = kl_key;
      end
      @(negedge clk);
      bus.key_load = 1'b0;
      if (i == 0) chk("aes_err_after_byte0", bus.aes_err, 1'b0);
    end
    if (keep_valid) bus.in_data = 8'haa;
    else            bus.in_valid = 1'b0;
    ct = model_ct(pt, exp_key);
    for (int i = 0; i < 16; i++) exp_q.push_back(ct[127-8*i -: 8]);
    chk("aes_start_pulse", bus.aes_start, 1'b1);
    chk("busy_start", bus.busy, 1'b1);
    chk("in_ready_start", bus.in_ready, 1'b0);
    @(negedge clk);
    chk("aes_start_one_cycle", bus.aes_start, 1'b0);
    chk("aes_plaintext", bus.aes_plaintext, pt);
    chk("aes_key", bus.aes_key, exp_key);
  endtask

  // Acts as the encryptor: after wait_cycles WAIT cycles returns a result
  // computed from the key/plaintext the sequencer presents.
  task automatic encrypt(input int wait_cycles);
    for (int i = 0; i < wait_cycles; i++) begin
      chk("wait_busy", bus.busy, 1'b1);
      chk("wait_in_ready", bus.in_ready, 1'b0);
      chk("wait_out_valid", bus.out_valid, 1'b0);
      chk("wait_aes_err", bus.aes_err, 1'b0);
      @(negedge clk);
    end
    bus.aes_ciphertext = model_ct(bus.aes_plaintext, bus.aes_key);
    bus.aes_valid      = 1'b1;
    @(negedge clk);
    bus.aes_valid      = 1'b0;
    bus.aes_ciphertext = '0;
  endtask

  // pattern 0: out_ready always high; pattern 1: one cycle on, three off.
  task automatic recv_block(input int pattern, input int n_bytes, input bit gating);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n_bytes && cyc < 200) begin
      chk("out_valid_send", bus.out_valid, 1'b1);
      if (exp_q.size() > 0) chk("out_data", bus.out_data, exp_q[0]);
      if (gating) chk("in_ready_gated", bus.in_ready, 1'b0);
      bus.out_ready = (pattern == 0) || (cyc % 4 == 0);
      @(negedge clk);
      if (bus.out_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        got++;
      end
      cyc++;
    end
    bus.out_ready = 1'b0;
    if (gating) bus.in_valid = 1'b0;
    if (got < n_bytes) timeout_fail("recv_block");
  endtask

  task automatic finish_block(input logic [127:0] pt);
    chk("blk_done_pulse", bus.blk_done, 1'b1);
    chk("in_ready_after_done", bus.in_ready, 1'b1);
    chk("out_valid_after_done", bus.out_valid, 1'b0);
    chk("out_data_after_done", bus.out_data, 8'h00);
    chk("busy_after_done", bus.busy, 1'b0);
    chk("plaintext_held", bus.aes_plaintext, pt);
    chk("scoreboard_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("blk_done_one_cycle", bus.blk_done, 1'b0);
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.key_in         = '0;
    bus.key_load       = 1'b0;
    bus.in_data        = '0;
    bus.in_valid       = 1'b0;
    bus.out_ready      = 1'b0;
    bus.aes_ciphertext = '0;
    bus.aes_valid      = 1'b0;
    exp_key            = '0;

    // Reset state.
    #12;
    reset_checks("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_post_reset", bus.in_ready, 1'b1);

    // Stray aes_valid in LOAD is ignored.
    bus.aes_valid      = 1'b1;
    bus.aes_ciphertext = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
    @(negedge clk);
    bus.aes_valid      = 1'b0;
    bus.aes_ciphertext = '0;
    chk("stray_valid_out_valid", bus.out_valid, 1'b0);
    chk("stray_valid_busy", bus.busy, 1'b0);

    // FIPS-197 vector, key loaded together with byte 0.
    send_block(FIPS_PT, 0, FIPS_KEY, 1'b0);
    encrypt(3);
    recv_block(0, 16, 1'b0);
    finish_block(FIPS_PT);

    // Back-to-back FIPS block: junk bytes offered through WAIT/SEND, 1-on/3-off sink.
`ifdef AES_SEQ_TIMEOUT_EN
    send_block(FIPS_PT, -1, '0, 1'b1);
    encrypt(5);
`else
    send_block(FIPS_PT, -1, '0, 1'b1);
    encrypt(80);
`endif
    recv_block(1, 16, 1'b1);
    finish_block(FIPS_PT);

    // key_load at byte_cnt=5 is ignored.
    send_block(FIPS_PT, 5, ALT_KEY, 1'b0);
    encrypt(1);
    recv_block(0, 16, 1'b0);
    finish_block(FIPS_PT);

    // Different key and plaintext; aes_valid in the first WAIT cycle.
    send_block(ALT_PT, 0, ALT_KEY, 1'b0);
    encrypt(0);
    recv_block(1, 16, 1'b0);
    finish_block(ALT_PT);

    // Reset during SEND after 7 bytes.
    send_block(FIPS_PT, 0, FIPS_KEY, 1'b0);
    encrypt(2);
    recv_block(0, 7, 1'b0);
    rst_n = 1'b0;
    #1;
    reset_checks("mid_send");
    exp_q.delete();
    exp_key = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_mid_reset", bus.in_ready, 1'b1);
    send_block(FIPS_PT, 0, FIPS_KEY, 1'b0);
    encrypt(2);
    recv_block(0, 16, 1'b0);
    finish_block(FIPS_PT);

`ifdef AES_SEQ_TIMEOUT_EN
    // Encryptor never answers: 64 WAIT cycles, then error and back to LOAD.
    send_block(FIPS_PT, -1, '0, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      chk("timeout_wait_busy", bus.busy, 1'b1);
      chk("timeout_wait_err", bus.aes_err, 1'b0);
      @(negedge clk);
    end
    chk("timeout_aes_err", bus.aes_err, 1'b1);
    chk("timeout_in_ready", bus.in_ready, 1'b1);
    chk("timeout_busy", bus.busy, 1'b0);
    chk("timeout_out_valid", bus.out_valid, 1'b0);
    bus.aes_valid      = 1'b1;
    bus.aes_ciphertext = FIPS_CT;
    @(negedge clk);
    bus.aes_valid      = 1'b0;
    bus.aes_ciphertext = '0;
    chk("late_valid_out_valid", bus.out_valid, 1'b0);
    chk("late_valid_err_sticky", bus.aes_err, 1'b1);
    send_block(FIPS_PT, -1, '0, 1'b0);
    encrypt(2);
    recv_block(0, 16, 1'b0);
    finish_block(FIPS_PT);
`else
    chk("aes_err_tied_low", bus.aes_err, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
